// File: rtl/msi_pkg.sv
// Shared definitions for the MSI serial link receiver: word width default,
// chip-select polarity and receive FSM state encoding.
package msi_pkg;

  localparam int   MSI_WORD_W    = 16;
  localparam logic MSI_CS_ACTIVE = 1'b0;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } msi_state_e;

endpackage

// File: rtl/msi_rx_fifo.sv
// First-word-fall-through synchronous FIFO for received MSI words.
// The head output holds the last popped word while empty.
module msi_rx_fifo #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WORD_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [WORD_W-1:0]        data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     drop_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_ONE = 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] hold_q;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q;
  logic              do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = level_q[AW];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop;
  assign level_o = level_q;
  assign data_o  = empty_o ? hold_q : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        hold_q   <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/msi_sdata_rx.sv
// MSI serial link receiver: oversamples CS/SCLK/SDATA in the clk domain,
// deserialises words during CS-low frames and queues them in a FWFT FIFO.
//
// state     | meaning
// WAIT_IDLE | after reset, wait for CS deasserted before joining any frame
// IDLE      | CS deasserted, waiting for frame start
// SHIFT     | frame active, shifting a bit in on every SCLK rise
module msi_sdata_rx
  import msi_pkg::*;
#(
  parameter int WORD_W      = MSI_WORD_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic                          MSI_CS,
  input  logic                          MSI_SCLK,
  input  logic                          MSI_SDATA,
  output logic [WORD_W-1:0]             rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, sdata_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_s, sclk_s, sdata_s, sclk_rise;

  msi_state_e             state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]      shift_q, shift_d;
  logic                   word_done_q, word_done_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overflow_q;
  logic                   fifo_drop, fifo_full, fifo_empty;

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdata_s   = sdata_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_ff @(posedge clk) begin
    if (RST) begin
      cs_sync_q    <= '1;
      sclk_sync_q  <= '0;
      sdata_sync_q <= '0;
      sclk_prev_q  <= 1'b0;
      state_q      <= WAIT_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      word_done_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      cs_sync_q    <= {cs_sync_q[SYNC_STAGES-2:0], MSI_CS};
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], MSI_SCLK};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], MSI_SDATA};
      sclk_prev_q  <= sclk_s;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      word_done_q  <= word_done_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= fifo_drop;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    word_done_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      WAIT_IDLE: if (cs_s != MSI_CS_ACTIVE) state_d = IDLE;
      IDLE: begin
        if (cs_s == MSI_CS_ACTIVE) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        // CS deassertion takes priority over a coincident SCLK rise
        if (cs_s != MSI_CS_ACTIVE) begin
          frame_err_d = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          state_d     = IDLE;
        end else if (sclk_rise) begin
          if (MSB_FIRST != 0) shift_d = {shift_q[WORD_W-2:0], sdata_s};
          else                shift_d = {sdata_s, shift_q[WORD_W-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d   = '0;
            word_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // Completed word is pushed one cycle after its last bit lands in shift_q
  msi_rx_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (RST),
    .push_i      (word_done_q),
    .push_data_i (shift_q),
    .pop_i       (rx_ready),
    .data_o      (rx_data),
    .level_o     (rx_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .drop_o      (fifo_drop)
  );

  assign rx_valid  = ~fifo_empty;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_msi_sdata_rx.sv
// Directed bench for msi_sdata_rx: table of single frames plus hand-written
// sequences for latency, FIFO overflow/simultaneous push-pop, reset and LSB-first.
module tb_msi_sdata_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rst_lsb = 1'b1;
  logic        cs = 1'b1, sclk = 1'b0, sdata = 1'b0, rx_ready = 1'b0;
  logic [15:0] rx_data, rx_data_l;
  logic        rx_valid, rx_valid_l, frame_err, frame_err_l, overflow, overflow_l;
  logic [2:0]  rx_level, rx_level_l;

  int pass_cnt = 0, total_cnt = 0;
  int fe_cnt = 0, ov_cnt = 0;
  int fe0, ov0;

  always #5 clk = ~clk;

  msi_sdata_rx #(.WORD_W(16), .FIFO_DEPTH(4), .MSB_FIRST(1), .SYNC_STAGES(2)) dut (
    .clk(clk), .RST(rst), .MSI_CS(cs), .MSI_SCLK(sclk), .MSI_SDATA(sdata),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_level(rx_level),
    .frame_err(frame_err), .overflow(overflow));

  msi_sdata_rx #(.WORD_W(16), .FIFO_DEPTH(4), .MSB_FIRST(0), .SYNC_STAGES(2)) dut_lsb (
    .clk(clk), .RST(rst_lsb), .MSI_CS(cs), .MSI_SCLK(sclk), .MSI_SDATA(sdata),
    .rx_data(rx_data_l), .rx_valid(rx_valid_l), .rx_ready(rx_ready), .rx_level(rx_level_l),
    .frame_err(frame_err_l), .overflow(overflow_l));

  always @(posedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overflow)  ov_cnt <= ov_cnt + 1;
  end

  typedef struct {
    logic [15:0] word;
    int          nbits;
    logic        exp_valid;
    logic [15:0] exp_data;
    int          exp_ferr;
  } vec_t;
  vec_t vecs[5];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic bit_out(input logic b);
    sdata = b; sclk = 1'b0; tick(4);
    sclk = 1'b1; tick(4);
  endtask

  // wire order: w[15] first
  task automatic send_word(input logic [15:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) bit_out(w[15-i]);
  endtask

  task automatic frame(input logic [15:0] w, input int nbits);
    cs = 1'b0; tick(4);
    send_word(w, nbits);
    sclk = 1'b0; tick(4);
    cs = 1'b1; tick(8);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h5A5A, 9,  1'b0, 16'h0000, 1};
    vecs[1] = '{16'h1234, 16, 1'b1, 16'h1234, 0};
    vecs[2] = '{16'hFFFF, 16, 1'b1, 16'hFFFF, 0};
    vecs[3] = '{16'h0000, 16, 1'b1, 16'h0000, 0};
    vecs[4] = '{16'h8001, 16, 1'b1, 16'h8001, 0};

    // reset state
    tick(3);
    check("rst_valid", rx_valid, 0);
    check("rst_level", rx_level, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0; tick(6);

    // latency on 0xA5C3
    cs = 1'b0; tick(4);
    send_word(16'hA5C3, 15);
    sdata = 1'b1; sclk = 1'b0; tick(4);
    sclk = 1'b1; tick(3);
    check("lat_not_early", rx_valid, 0);
    tick(1);
    check("lat_valid", rx_valid, 1);
    check("lat_data", rx_data, 16'hA5C3);
    check("lat_level", rx_level, 1);
    sclk = 1'b0; tick(4);
    cs = 1'b1; tick(8);
    pop_one();
    check("pop_empty", rx_valid, 0);
    check("hold_data", rx_data, 16'hA5C3);

    // table of single frames (partial frame first, then full words)
    for (int k = 0; k < 5; k++) begin
      fe0 = fe_cnt;
      frame(vecs[k].word, vecs[k].nbits);
      check($sformatf("v%0d_ferr", k), fe_cnt - fe0, vecs[k].exp_ferr);
      check($sformatf("v%0d_valid", k), rx_valid, vecs[k].exp_valid);
      if (vecs[k].exp_valid) begin
        check($sformatf("v%0d_data", k), rx_data, vecs[k].exp_data);
        check($sformatf("v%0d_level", k), rx_level, 1);
        pop_one();
      end
      check($sformatf("v%0d_empty", k), rx_level, 0);
    end

    // five words in one frame, no consumer: fifth dropped
    ov0 = ov_cnt;
    cs = 1'b0; tick(4);
    for (int k = 1; k <= 5; k++) send_word(16'(k), 16);
    sclk = 1'b0; tick(4);
    cs = 1'b1; tick(8);
    check("ovf_pulses", ov_cnt - ov0, 1);
    check("ovf_level", rx_level, 4);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovf_drain%0d", k), rx_data, 16'(k));
      pop_one();
    end
    check("ovf_empty", rx_valid, 0);

    // full FIFO, pop coincides with fifth push
    ov0 = ov_cnt;
    cs = 1'b0; tick(4);
    for (int k = 1; k <= 4; k++) send_word(16'(k), 16);
    send_word(16'h0005, 15);
    sdata = 1'b1; sclk = 1'b0; tick(4);
    sclk = 1'b1; tick(3);
    rx_ready = 1'b1; tick(1); rx_ready = 1'b0;
    tick(3);
    sclk = 1'b0; tick(4);
    cs = 1'b1; tick(8);
    check("pp_no_ovf", ov_cnt - ov0, 0);
    check("pp_level", rx_level, 4);
    for (int k = 2; k <= 5; k++) begin
      check($sformatf("pp_drain%0d", k), rx_data, 16'(k));
      pop_one();
    end

    // reset mid-frame with a word already queued
    frame(16'h5555, 16);
    check("pre_rst_level", rx_level, 1);
    cs = 1'b0; tick(4);
    send_word(16'hC0DE, 7);
    rst = 1'b1; tick(1); rst = 1'b0;
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_level", rx_level, 0);
    check("mid_rst_data", rx_data, 0);
    send_word(16'h01FF, 9);
    sclk = 1'b0; tick(4);
    check("mid_rst_noword", rx_valid, 0);
    cs = 1'b1; tick(8);
    frame(16'hBEEF, 16);
    check("after_rst_data", rx_data, 16'hBEEF);
    check("after_rst_level", rx_level, 1);
    pop_one();

    // LSB-first instance
    rst_lsb = 1'b0; tick(6);
    frame(16'h8000, 16);
    check("lsb_valid", rx_valid_l, 1);
    check("lsb_data", rx_data_l, 16'h0001);
    check("msb_same_wire", rx_data, 16'h8000);
    pop_one();
    check("lsb_empty", rx_level_l, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
